// File: rtl/chunked_addsub_unit_if.sv
// Handshake and operand/result bundle for chunked_addsub_unit.
// The slave modport is the unit side; the master modport is the producer/consumer side.
interface chunked_addsub_unit_if #(
    parameter int unsigned WIDTH = 64
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             cb;
    logic             overflow;
    logic             zero;
    logic             negative;

    modport slave (
        input  in_valid, a, b, sub, out_ready,
        output in_ready, out_valid, result, cb, overflow, zero, negative
    );

    modport master (
        output in_valid, a, b, sub, out_ready,
        input  in_ready, out_valid, result, cb, overflow, zero, negative
    );
endinterface

// File: rtl/chunked_addsub_unit.sv
// Multi-cycle add/subtract, CHUNK bits per cycle LSB first, with carry held between cycles.
// Optional macro ADDSUB_SAT_EN clamps the result on signed overflow.
module chunked_addsub_unit #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned CHUNK = 16
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    chunked_addsub_unit_if.slave  io_bus
);
    localparam int unsigned N       = WIDTH / CHUNK;
    localparam int unsigned IdxW    = (N > 1) ? $clog2(N) : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(N - 1);
    localparam logic [WIDTH-1:0] SatMax = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SatMin = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e            r_state, w_state_next;
    logic [WIDTH-1:0]  r_a, r_b, r_result;
    logic              r_sub, r_carry;
    logic [IdxW-1:0]   r_idx;
    logic              r_cb, r_overflow, r_zero, r_negative;

    int unsigned       w_base;
    logic [CHUNK-1:0]  w_a_chunk, w_b_eff;
    logic [CHUNK:0]    w_sum;
    logic [WIDTH-1:0]  w_raw, w_final;
    logic              w_ovf, w_last, w_in_ready, w_out_valid;

    // Datapath for the current chunk step; w_raw is the result with this chunk merged in.
    always_comb begin
        w_base    = 32'(r_idx) * CHUNK;
        w_a_chunk = r_a[w_base +: CHUNK];
        w_b_eff   = r_sub ? ~r_b[w_base +: CHUNK] : r_b[w_base +: CHUNK];
        w_sum     = {1'b0, w_a_chunk} + {1'b0, w_b_eff} + (CHUNK+1)'(r_carry);
        w_raw     = r_result;
        w_raw[w_base +: CHUNK] = w_sum[CHUNK-1:0];
        w_last    = (r_idx == LastIdx);
        if (r_sub) begin
            w_ovf = (r_a[WIDTH-1] != r_b[WIDTH-1]) && (w_raw[WIDTH-1] != r_a[WIDTH-1]);
        end else begin
            w_ovf = (r_a[WIDTH-1] == r_b[WIDTH-1]) && (w_raw[WIDTH-1] != r_a[WIDTH-1]);
        end
`ifdef ADDSUB_SAT_EN
        // On overflow the true result has the sign of a.
        w_final = w_ovf ? (r_a[WIDTH-1] ? SatMin : SatMax) : w_raw;
`else
        w_final = w_raw;
`endif
    end

    always_comb begin
        w_state_next = r_state;
        w_in_ready   = 1'b0;
        w_out_valid  = 1'b0;
        case (r_state)
            StIdle: begin
                w_in_ready = 1'b1;
                if (io_bus.in_valid) w_state_next = StRun;
            end
            StRun: begin
                if (w_last) w_state_next = StDone;
            end
            StDone: begin
                w_out_valid = 1'b1;
                if (io_bus.out_ready) w_state_next = StIdle;
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state    <= StIdle;
            r_a        <= '0;
            r_b        <= '0;
            r_sub      <= 1'b0;
            r_carry    <= 1'b0;
            r_idx      <= '0;
            r_result   <= '0;
            r_cb       <= 1'b0;
            r_overflow <= 1'b0;
            r_zero     <= 1'b0;
            r_negative <= 1'b0;
        end else begin
            r_state <= w_state_next;
            case (r_state)
                StIdle: begin
                    if (io_bus.in_valid) begin
                        r_a     <= io_bus.a;
                        r_b     <= io_bus.b;
                        r_sub   <= io_bus.sub;
                        r_carry <= io_bus.sub;
                        r_idx   <= '0;
                    end
                end
                StRun: begin
                    r_carry <= w_sum[CHUNK];
                    r_idx   <= r_idx + IdxW'(1);
                    if (w_last) begin
                        r_result   <= w_final;
                        r_cb       <= r_sub ? ~w_sum[CHUNK] : w_sum[CHUNK];
                        r_overflow <= w_ovf;
                        r_zero     <= (w_final == '0);
                        r_negative <= w_final[WIDTH-1];
                    end else begin
                        r_result <= w_raw;
                    end
                end
                default: ;
            endcase
        end
    end

    assign io_bus.in_ready  = w_in_ready;
    assign io_bus.out_valid = w_out_valid;
    assign io_bus.result    = r_result;
    assign io_bus.cb        = r_cb;
    assign io_bus.overflow  = r_overflow;
    assign io_bus.zero      = r_zero;
    assign io_bus.negative  = r_negative;
endmodule

// File: tb/tb_chunked_addsub_unit.sv
// Self-checking bench for chunked_addsub_unit: directed vectors, back-pressure, reset abort,
// and random operations against a signed/unsigned arithmetic reference model.
module tb_chunked_addsub_unit;
    localparam int unsigned W = 64;
    localparam int unsigned C = 16;
    localparam int unsigned N = W / C;
    localparam logic signed [65:0] MaxS = 66'sh0_7FFF_FFFF_FFFF_FFFF;
    localparam logic signed [65:0] MinS = 66'sh3_8000_0000_0000_0000;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    chunked_addsub_unit_if #(.WIDTH(W)) bus ();

    chunked_addsub_unit #(.WIDTH(W), .CHUNK(C)) dut (
        .i_clk   (clk),
        .i_reset (reset),
        .io_bus  (bus.slave)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Reference: exact signed arithmetic in 66 bits, unsigned compare for carry/borrow.
    task automatic model(input logic [63:0] a, input logic [63:0] b, input logic s,
                         output logic [63:0] r, output logic cb, output logic ov,
                         output logic z, output logic n);
        logic signed [65:0] t;
        logic [64:0] u;
        if (s) t = $signed({{2{a[63]}}, a}) - $signed({{2{b[63]}}, b});
        else   t = $signed({{2{a[63]}}, a}) + $signed({{2{b[63]}}, b});
        u  = {1'b0, a} + {1'b0, b};
        r  = t[63:0];
        cb = s ? (a < b) : u[64];
        ov = (t > MaxS) || (t < MinS);
`ifdef ADDSUB_SAT_EN
        if (ov) r = (t < 0) ? 64'h8000_0000_0000_0000 : 64'h7FFF_FFFF_FFFF_FFFF;
`endif
        z = (r == 64'd0);
        n = r[63];
    endtask

    task automatic run_op(input logic [63:0] a, input logic [63:0] b, input logic s,
                          input int hold);
        logic [63:0] er;
        logic ecb, eov, ez, en;
        int k;
        model(a, b, s, er, ecb, eov, ez, en);
        bus.a = a;
        bus.b = b;
        bus.sub = s;
        bus.in_valid = 1'b1;
        bus.out_ready = (hold == 0);
        chk1("in_ready_idle", bus.in_ready, 1'b1);
        @(posedge clk); #1;
        // Scramble inputs after acceptance; the unit must ignore them.
        bus.in_valid = 1'b0;
        bus.a = {$urandom, $urandom};
        bus.b = {$urandom, $urandom};
        bus.sub = ~s;
        k = 0;
        while (!bus.out_valid && k < 20) begin
            chk1("in_ready_run", bus.in_ready, 1'b0);
            @(posedge clk); #1;
            k++;
        end
        chk("latency", 64'(k), 64'(N));
        chk("result", bus.result, er);
        chk1("cb", bus.cb, ecb);
        chk1("overflow", bus.overflow, eov);
        chk1("zero", bus.zero, ez);
        chk1("negative", bus.negative, en);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk1("hold_valid", bus.out_valid, 1'b1);
            chk1("hold_in_ready", bus.in_ready, 1'b0);
            chk("hold_result", bus.result, er);
            chk1("hold_cb", bus.cb, ecb);
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        chk1("post_valid", bus.out_valid, 1'b0);
        chk1("post_in_ready", bus.in_ready, 1'b1);
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        bus.a = '0;
        bus.b = '0;
        bus.sub = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        chk1("rst_in_ready", bus.in_ready, 1'b1);
        chk1("rst_out_valid", bus.out_valid, 1'b0);
        chk("rst_result", bus.result, 64'd0);
        chk1("rst_cb", bus.cb, 1'b0);
        chk1("rst_overflow", bus.overflow, 1'b0);
        chk1("rst_zero", bus.zero, 1'b0);
        chk1("rst_negative", bus.negative, 1'b0);

        run_op(64'd5, 64'd3, 1'b1, 0);
        run_op(64'd3, 64'd5, 1'b1, 0);
        run_op(64'h8000_0000_0000_0000, 64'd1, 1'b1, 0);
        run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 0);
        run_op(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 0);
        run_op(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0, 5);

        // Reset in the middle of RUN aborts the operation.
        bus.a = 64'h1111_2222_3333_4444;
        bus.b = 64'h0000_0000_0000_0007;
        bus.sub = 1'b0;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk1("abort_out_valid", bus.out_valid, 1'b0);
        chk1("abort_in_ready", bus.in_ready, 1'b1);
        chk("abort_result", bus.result, 64'd0);
        chk1("abort_cb", bus.cb, 1'b0);
        chk1("abort_overflow", bus.overflow, 1'b0);
        chk1("abort_zero", bus.zero, 1'b0);
        chk1("abort_negative", bus.negative, 1'b0);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            chk1("abort_no_output", bus.out_valid, 1'b0);
        end
        run_op(64'd42, 64'd42, 1'b1, 0);

        for (int i = 0; i < 24; i++) begin
            logic [63:0] ra, rb;
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            if (i % 6 == 1) rb = ra;
            if (i % 6 == 2) rb = ~ra + 64'd1;
            run_op(ra, rb, 1'($urandom), int'($urandom_range(0, 3)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/chunked_addsub_unit.md
# chunked_addsub_unit

Parametrised, multi-cycle signed/unsigned add/subtract unit for the execute stage. Operands of WIDTH bits are processed CHUNK bits per cycle, least-significant chunk first, with the carry/borrow held in a register between cycles. This trades latency for a short critical path. The unit uses valid/ready handshakes on input and output, and reports carry/borrow, signed overflow, zero and negative flags.

## Interface
- WIDTH, 64: operand and result width; must be a multiple of CHUNK.
- CHUNK, 16: bits processed per cycle; 1 ≤ CHUNK ≤ WIDTH.
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  operands and mode are valid.
- in_ready  output  1  unit can accept an operation.
- a  input  WIDTH  minuend / first addend.
- b  input  WIDTH  subtrahend / second addend.
- sub  input  1  1 = a − b, 0 = a + b.
- out_valid  output  1  result and flags are valid.
- out_ready  input  1  consumer accepts the result.
- result  output  WIDTH  sum/difference.
- cb  output  1  add: carry out of the MSB; sub: borrow (1 iff a < b unsigned).
- overflow  output  1  signed overflow of the true result.
- zero  output  1  result == 0.
- negative  output  1  result[WIDTH−1].

## Operation
- N = WIDTH/CHUNK chunk steps per operation; idx counts 0..N−1.
- FSM states:
  - IDLE: in_ready=1. On in_valid&&in_ready, capture a, b and sub into internal registers; set idx=0; set the carry register to sub (1 for subtract, 0 for add); go to RUN.
  - RUN: each cycle compute {c, r} = a_chunk + (sub ? ~b_chunk : b_chunk) + carry. Write r into result[idx*CHUNK +: CHUNK]; carry <= c; idx++. After the step with idx==N−1, go to DONE.
  - DONE: out_valid=1. Hold all outputs stable until out_ready; on out_valid&&out_ready, go to IDLE.
- Subtraction is two's-complement: a + ~b + 1. Borrow cb = ~final carry. Add cb = final carry.
- overflow: add = (a[MSB]==b[MSB]) && (raw[MSB]!=a[MSB]); sub = (a[MSB]!=b[MSB]) && (raw[MSB]!=a[MSB]). raw is the unsaturated result.
- zero and negative are computed from the final (possibly saturated) result.
- Changes on a, b or sub after acceptance are ignored.
- in_ready is 0 in RUN and DONE. There is no same-cycle accept while the unit is in DONE.
- result bits not yet written in RUN hold their previous values. They are not observable because out_valid=0.

## Timing
- Reset:
  - state=IDLE, in_ready=1, out_valid=0.
  - result, cb, overflow, zero and negative are all 0.
  - The carry register and idx are cleared.
- Reset in RUN or DONE aborts the operation, discards any pending result, and produces no output handshake.
- Latency: when accepted at edge t, out_valid rises after edge t+N. Example: N=4 for the defaults.
- Throughput: at most one operation per N+2 cycles with out_ready held at 1.
- Back-pressure: out_ready low in DONE holds result and flags unchanged indefinitely.
- in_ready returns to 1 in the cycle after the output handshake.
- CHUNK==WIDTH degenerates to N=1: one RUN cycle.

## Configuration
- ADDSUB_SAT_EN:
  - Defined: on overflow, result saturates. It is clamped to 2^(WIDTH−1)−1 if the true result is positive, and to −2^(WIDTH−1) if negative. overflow still reads 1, and cb is unaffected.
  - Undefined: result wraps modulo 2^WIDTH.
  - Saturation is applied on the RUN→DONE transition, so latency is identical in both builds.

## Test plan
- Defaults, sub=1, a=5, b=3:
  - result=2, cb=0, overflow=0, zero=0, negative=0.
  - out_valid rises exactly 4 edges after accept.
- sub=1, a=3, b=5: result=0xFFFF_FFFF_FFFF_FFFE, cb=1, overflow=0, negative=1.
- sub=1, a=0x8000_0000_0000_0000, b=1:
  - Without the macro: result=0x7FFF_FFFF_FFFF_FFFF, overflow=1, cb=0.
  - With ADDSUB_SAT_EN: result=0x8000_0000_0000_0000, overflow=1.
- sub=0, a=0xFFFF_FFFF_FFFF_FFFF, b=1: result=0, cb=1, zero=1, overflow=0. This exercises carry rippling across all chunk boundaries.
- Back-pressure: hold out_ready=0 for 5 cycles in DONE, and change a/b during RUN.
  - Result stays unchanged and in_ready=0 throughout.
  - After out_ready=1, in_ready=1 on the next cycle.
- Assert reset for 1 cycle in the middle of RUN: next cycle out_valid=0, in_ready=1, all outputs 0, and a new operation completes correctly.
